rvga_mem_arbiter: RTL and testbench
===================================

// Module: rvga_mem_arbiter
// PURPOSE
//  Parametrised N-requester arbiter that merges the core's memory clients onto one backing memory port.
//  Default clients: imem and dmem. Further clients (e.g. debug, DMA) are added by raising NUM_PORTS.
//  Sits between the pipeline top and a single-ported memory.
//  Provides round-robin or fixed-priority arbitration, one outstanding transaction, and a response watchdog.
// PARAMETERS
//  NUM_PORTS     2   number of requesters; port 0 = imem, port 1 = dmem
//  WORD_WIDTH    32  address/data width; equals the rvga_word width
//  PRIORITY_MODE 0   0 = round-robin; 1 = fixed priority, lowest index wins
//  TIMEOUT       64  max cycles in BUSY before abort; 0 disables the watchdog
// PORTS
//  clk_i          in   1                     clock
//  rst_i          in   1                     synchronous, active-high reset
//  req_r_v_i      in   NUM_PORTS             per-port read request
//  req_w_v_i      in   NUM_PORTS             per-port write request
//  req_addr_i     in   NUM_PORTS*WORD_WIDTH  per-port address; port p at bits [p*W +: W]
//  req_data_i     in   NUM_PORTS*WORD_WIDTH  per-port write data, same packing
//  resp_v_o       out  NUM_PORTS             one-hot; completion for the granted port
//  resp_data_o    out  WORD_WIDTH            read data, shared by all ports
//  mem_r_v_o      out  1                     backing memory read strobe
//  mem_w_v_o      out  1                     backing memory write strobe
//  mem_addr_o     out  WORD_WIDTH            backing memory address
//  mem_data_o     out  WORD_WIDTH            backing memory write data
//  mem_data_i     in   WORD_WIDTH            backing memory read data
//  mem_resp_v_i   in   1                     backing memory completion
//  grant_o        out  NUM_PORTS             one-hot current owner; 0 in IDLE
//  timeout_err_o  out  1                     sticky watchdog error flag
// BEHAVIOUR
//  Reset values: state=IDLE; grant_o, resp_v_o, mem_r_v_o, mem_w_v_o = 0; mem_addr_o, mem_data_o = 0.
//    rr_ptr=0; wait counter=0; timeout_err_o=0. Reset mid-transaction abandons it; no resp_v_o is issued.
//  Requesters:
//    - Hold r_v/w_v, addr and data stable until their resp_v_o bit pulses.
//    - r_v and w_v both set on one port: treat as a write.
//  FSM state IDLE:
//    - Port p is pending if r_v[p] or w_v[p] is set.
//    - No pending port: stay in IDLE.
//    - Otherwise pick a winner g, then on the next edge:
//      register grant_o = 1<<g; latch addr, data and r/w of g into the mem_* output registers; go to BUSY.
//  Winner selection:
//    - PRIORITY_MODE=0: first pending index at or above rr_ptr, wrapping modulo NUM_PORTS.
//      On grant, rr_ptr <= (g+1) mod NUM_PORTS.
//    - PRIORITY_MODE=1: lowest pending index; rr_ptr is unused.
//  FSM state BUSY:
//    - mem_* outputs are held constant.
//    - mem_resp_v_i=1 in the same cycle (combinational):
//        resp_v_o = grant_o; resp_data_o = mem_data_i.
//      On the following edge: clear grant_o, mem_r_v_o and mem_w_v_o; go to IDLE.
//    - resp_data_o is don't-care when resp_v_o=0; hold it at mem_data_i.
//  Latency and throughput:
//    - A request first seen in cycle t drives mem_*_v_o from t+1.
//    - Minimum turnaround is 2 cycles per transaction (the IDLE cycle plus the grant cycle).
//    - No back-to-back grant is allowed in the response cycle.
//  Watchdog (TIMEOUT>0):
//    - The counter clears on entry to BUSY and increments every BUSY cycle without mem_resp_v_i.
//    - When it reaches TIMEOUT: set timeout_err_o (sticky until rst_i), drop the mem strobes, go to IDLE.
//      No resp_v_o is issued for the aborted transaction, so the requester stays pending and is re-arbitrated.
//    - mem_resp_v_i in the same cycle the limit is reached: the response wins and no error is flagged.
//  Edge cases:
//    - mem_resp_v_i while in IDLE is ignored.
//    - A requester deasserting while granted is a protocol violation; the transaction still completes.
//  Widths: the index and rr_ptr use $clog2(NUM_PORTS), minimum 1 bit. The counter uses $clog2(TIMEOUT+1) bits.
// TESTING
//  1. Single read on port 1, addr=0x100; memory answers 3 cycles later with 0xDEADBEEF.
//     -> mem_r_v_o=1 and mem_addr_o=0x100 from t+1; resp_v_o=2'b10 and resp_data_o=0xDEADBEEF for 1 cycle.
//  2. RR mode, both ports requesting continuously, memory answers every cycle.
//     -> grants alternate 0,1,0,1; each port gets one resp_v_o per 4 cycles.
//  3. Fixed mode, ports 0 and 1 requesting continuously.
//     -> port 0 always wins; port 1 is never granted while port 0 is held.
//  4. Port 0 write (addr=0x40, data=0x12345678) with port 1 read pending.
//     -> mem_w_v_o=1 with those values; after its resp, port 1 is granted; mem_w_v_o=0 and mem_r_v_o=1.
//  5. TIMEOUT=4 and memory never responds.
//     -> after 4 BUSY cycles timeout_err_o=1 and strobes drop; the requester is re-granted; the flag stays set.
//  6. rst_i asserted mid-BUSY, then NUM_PORTS=4 with ports 1 and 3 pending and rr_ptr=2.
//     -> after reset all outputs are 0 and rr_ptr=0; then port 1 is granted first (3 wins when rr_ptr=2).

Source files
------------

// File: rtl/rvga_mem_arbiter.sv
// rvga_mem_arbiter
// Merges NUM_PORTS memory clients (port 0 = imem, port 1 = dmem, extra ports
// for debug/DMA) onto one single-ported backing memory. One transaction is
// outstanding at a time. Arbitration is round-robin (PRIORITY_MODE=0) or fixed
// priority with the lowest index winning (PRIORITY_MODE=1). A watchdog aborts
// a transaction that has waited TIMEOUT BUSY cycles (TIMEOUT=0 disables it).
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   req_r_v_i/w_v_i   per-port read/write request (both set = write)
//   req_addr_i        per-port address, port p at [p*WORD_WIDTH +: WORD_WIDTH]
//   req_data_i        per-port write data, same packing
//   resp_v_o          one-hot completion pulse for the granted port
//   resp_data_o       read data, shared by all ports (follows mem_data_i)
//   mem_r_v_o/w_v_o   backing memory read/write strobes (registered)
//   mem_addr_o        backing memory address (registered)
//   mem_data_o        backing memory write data (registered)
//   mem_data_i        backing memory read data
//   mem_resp_v_i      backing memory completion
//   grant_o           one-hot current owner, zero while idle; doubles as the
//                     FSM state view (non-zero exactly when BUSY)
//   timeout_err_o     sticky watchdog error, cleared only by rst_i
//
// Handshake: a requester raises r_v and/or w_v with addr/data and holds all of
// them stable until its resp_v_o bit pulses for one cycle; it may drop or
// re-raise the request in that same cycle. The memory sees strobes that stay
// constant from the grant until it answers with mem_resp_v_i (one cycle).
module rvga_mem_arbiter #(
    parameter int NUM_PORTS     = 2,
    parameter int WORD_WIDTH    = 32,
    parameter int PRIORITY_MODE = 0,
    parameter int TIMEOUT       = 64
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_PORTS-1:0]            req_r_v_i,
    input  logic [NUM_PORTS-1:0]            req_w_v_i,
    input  logic [NUM_PORTS*WORD_WIDTH-1:0] req_addr_i,
    input  logic [NUM_PORTS*WORD_WIDTH-1:0] req_data_i,
    output logic [NUM_PORTS-1:0]            resp_v_o,
    output logic [WORD_WIDTH-1:0]           resp_data_o,
    output logic                            mem_r_v_o,
    output logic                            mem_w_v_o,
    output logic [WORD_WIDTH-1:0]           mem_addr_o,
    output logic [WORD_WIDTH-1:0]           mem_data_o,
    input  logic [WORD_WIDTH-1:0]           mem_data_i,
    input  logic                            mem_resp_v_i,
    output logic [NUM_PORTS-1:0]            grant_o,
    output logic                            timeout_err_o
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e                  state_q;
    logic [NUM_PORTS-1:0]    grant_q;
    logic                    mem_r_v_q;
    logic                    mem_w_v_q;
    logic [WORD_WIDTH-1:0]   mem_addr_q;
    logic [WORD_WIDTH-1:0]   mem_data_q;
    logic [IDX_W-1:0]        rr_ptr_q;
    logic [CNT_W-1:0]        wait_cnt_q;
    logic                    timeout_err_q;

    logic [NUM_PORTS-1:0]    pending;
    logic [NUM_PORTS-1:0]    above_mask;
    logic [NUM_PORTS-1:0]    masked;
    logic                    any_pending;
    logic [IDX_W-1:0]        win_idx;
    logic [IDX_W-1:0]        win_next_ptr;
    logic [WORD_WIDTH-1:0]   win_addr;
    logic [WORD_WIDTH-1:0]   win_data;
    logic                    win_is_write;
    logic                    limit_hit;

    // Index of the lowest set bit; zero when the vector is empty.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_PORTS-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    always_comb begin
        pending     = req_r_v_i | req_w_v_i;
        any_pending = |pending;
        above_mask  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            above_mask[i] = (i >= int'(rr_ptr_q));
        end
        masked = pending & above_mask;
        // Round-robin: lowest pending port at or above the pointer; if none,
        // wrap around and take the lowest pending port overall.
        if ((PRIORITY_MODE == 0) && (masked != '0)) begin
            win_idx = lowest_set(masked);
        end else begin
            win_idx = lowest_set(pending);
        end
        win_next_ptr = (int'(win_idx) == NUM_PORTS - 1) ? '0 : win_idx + 1'b1;
        win_addr     = req_addr_i[int'(win_idx)*WORD_WIDTH +: WORD_WIDTH];
        win_data     = req_data_i[int'(win_idx)*WORD_WIDTH +: WORD_WIDTH];
        win_is_write = req_w_v_i[win_idx];
        // The counter holds the number of BUSY cycles already waited, so the
        // limit is reached in the cycle where it would step to TIMEOUT.
        limit_hit    = (TIMEOUT > 0) && (wait_cnt_q == CNT_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            mem_r_v_q     <= 1'b0;
            mem_w_v_q     <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_q    <= '0;
            rr_ptr_q      <= '0;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_pending) begin
                        state_q    <= ST_BUSY;
                        grant_q    <= NUM_PORTS'(1) << win_idx;
                        mem_r_v_q  <= ~win_is_write;
                        mem_w_v_q  <= win_is_write;
                        mem_addr_q <= win_addr;
                        mem_data_q <= win_data;
                        wait_cnt_q <= '0;
                        if (PRIORITY_MODE == 0) begin
                            rr_ptr_q <= win_next_ptr;
                        end
                    end
                end
                ST_BUSY: begin
                    if (mem_resp_v_i) begin
                        // A response in the limit cycle still wins over the watchdog.
                        state_q   <= ST_IDLE;
                        grant_q   <= '0;
                        mem_r_v_q <= 1'b0;
                        mem_w_v_q <= 1'b0;
                    end else if (limit_hit) begin
                        // Abort silently: the requester keeps its request up
                        // and is arbitrated again from IDLE.
                        state_q       <= ST_IDLE;
                        grant_q       <= '0;
                        mem_r_v_q     <= 1'b0;
                        mem_w_v_q     <= 1'b0;
                        timeout_err_q <= 1'b1;
                    end else if (TIMEOUT > 0) begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign resp_v_o      = ((state_q == ST_BUSY) && mem_resp_v_i) ? grant_q : '0;
    assign resp_data_o   = mem_data_i;
    assign mem_r_v_o     = mem_r_v_q;
    assign mem_w_v_o     = mem_w_v_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_data_o    = mem_data_q;
    assign grant_o       = grant_q;
    assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_rvga_mem_arbiter.sv
// Bench for rvga_mem_arbiter. Three instances share clock and reset:
//   a: 2 ports, round-robin, TIMEOUT=4
//   f: 2 ports, fixed priority, watchdog disabled
//   q: 4 ports, round-robin, TIMEOUT=8 (reset-mid-busy and random traffic)
module tb_rvga_mem_arbiter;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [W-1:0] exp_q[$];

    // ---- instance a signals ----
    logic [1:0]     a_r_v, a_w_v, a_resp_v, a_grant;
    logic [2*W-1:0] a_addr, a_wdata;
    logic [W-1:0]   a_resp_data, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic           a_mem_r_v, a_mem_w_v, a_mem_resp, a_err;
    // ---- instance f signals ----
    logic [1:0]     f_r_v, f_w_v, f_resp_v, f_grant;
    logic [2*W-1:0] f_addr, f_wdata;
    logic [W-1:0]   f_resp_data, f_mem_addr, f_mem_wdata, f_mem_rdata;
    logic           f_mem_r_v, f_mem_w_v, f_mem_resp, f_err;
    // ---- instance q signals ----
    logic [3:0]     q_r_v, q_w_v, q_resp_v, q_grant;
    logic [4*W-1:0] q_addr, q_wdata;
    logic [W-1:0]   q_resp_data, q_mem_addr, q_mem_wdata, q_mem_rdata;
    logic           q_mem_r_v, q_mem_w_v, q_mem_resp, q_err;

    rvga_mem_arbiter #(.NUM_PORTS(2), .WORD_WIDTH(W), .PRIORITY_MODE(0), .TIMEOUT(4)) u_a (
        .clk_i(clk), .rst_i(rst), .req_r_v_i(a_r_v), .req_w_v_i(a_w_v),
        .req_addr_i(a_addr), .req_data_i(a_wdata), .resp_v_o(a_resp_v),
        .resp_data_o(a_resp_data), .mem_r_v_o(a_mem_r_v), .mem_w_v_o(a_mem_w_v),
        .mem_addr_o(a_mem_addr), .mem_data_o(a_mem_wdata), .mem_data_i(a_mem_rdata),
        .mem_resp_v_i(a_mem_resp), .grant_o(a_grant), .timeout_err_o(a_err));

    rvga_mem_arbiter #(.NUM_PORTS(2), .WORD_WIDTH(W), .PRIORITY_MODE(1), .TIMEOUT(0)) u_f (
        .clk_i(clk), .rst_i(rst), .req_r_v_i(f_r_v), .req_w_v_i(f_w_v),
        .req_addr_i(f_addr), .req_data_i(f_wdata), .resp_v_o(f_resp_v),
        .resp_data_o(f_resp_data), .mem_r_v_o(f_mem_r_v), .mem_w_v_o(f_mem_w_v),
        .mem_addr_o(f_mem_addr), .mem_data_o(f_mem_wdata), .mem_data_i(f_mem_rdata),
        .mem_resp_v_i(f_mem_resp), .grant_o(f_grant), .timeout_err_o(f_err));

    rvga_mem_arbiter #(.NUM_PORTS(4), .WORD_WIDTH(W), .PRIORITY_MODE(0), .TIMEOUT(8)) u_q (
        .clk_i(clk), .rst_i(rst), .req_r_v_i(q_r_v), .req_w_v_i(q_w_v),
        .req_addr_i(q_addr), .req_data_i(q_wdata), .resp_v_o(q_resp_v),
        .resp_data_o(q_resp_data), .mem_r_v_o(q_mem_r_v), .mem_w_v_o(q_mem_w_v),
        .mem_addr_o(q_mem_addr), .mem_data_o(q_mem_wdata), .mem_data_i(q_mem_rdata),
        .mem_resp_v_i(q_mem_resp), .grant_o(q_grant), .timeout_err_o(q_err));

    // ---- driver tasks ----
    task automatic clear_inputs();
        a_r_v = '0; a_w_v = '0; a_addr = '0; a_wdata = '0; a_mem_rdata = '0; a_mem_resp = 1'b0;
        f_r_v = '0; f_w_v = '0; f_addr = '0; f_wdata = '0; f_mem_rdata = '0; f_mem_resp = 1'b0;
        q_r_v = '0; q_w_v = '0; q_addr = '0; q_wdata = '0; q_mem_rdata = '0; q_mem_resp = 1'b0;
    endtask

    // Leaves the bench 1 time unit after a posedge, in the first cycle with rst low.
    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        do_reset();
        tests_run++; if (a_grant !== 2'b00) begin tests_failed++; $display("FAIL rst_a_grant: got %b want 00", a_grant); end
        tests_run++; if ({a_mem_r_v, a_mem_w_v} !== 2'b00) begin tests_failed++; $display("FAIL rst_a_strobes: got %b want 00", {a_mem_r_v, a_mem_w_v}); end
        tests_run++; if ({a_mem_addr, a_mem_wdata} !== 64'd0) begin tests_failed++; $display("FAIL rst_a_addr_data: got %h want 0", {a_mem_addr, a_mem_wdata}); end
        tests_run++; if ({a_resp_v, a_err} !== 3'b000) begin tests_failed++; $display("FAIL rst_a_resp_err: got %b want 000", {a_resp_v, a_err}); end
        tests_run++; if ({q_grant, q_resp_v, q_mem_r_v, q_mem_w_v, q_err} !== 11'd0) begin tests_failed++; $display("FAIL rst_q_outputs: got %b want 0", {q_grant, q_resp_v, q_mem_r_v, q_mem_w_v, q_err}); end
        tests_run++; if ({f_grant, f_resp_v, f_mem_r_v, f_mem_w_v, f_err} !== 7'd0) begin tests_failed++; $display("FAIL rst_f_outputs: got %b want 0", {f_grant, f_resp_v, f_mem_r_v, f_mem_w_v, f_err}); end
    endtask

    task automatic test_single_read();
        do_reset();
        a_r_v = 2'b10;
        a_addr[63:32] = 32'h0000_0100;
        tick();
        tests_run++; if (a_grant !== 2'b10) begin tests_failed++; $display("FAIL sr_grant: got %b want 10", a_grant); end
        tests_run++; if ({a_mem_r_v, a_mem_w_v} !== 2'b10) begin tests_failed++; $display("FAIL sr_strobes: got %b want 10", {a_mem_r_v, a_mem_w_v}); end
        tests_run++; if (a_mem_addr !== 32'h100) begin tests_failed++; $display("FAIL sr_addr: got %h want 100", a_mem_addr); end
        tests_run++; if (a_resp_v !== 2'b00) begin tests_failed++; $display("FAIL sr_no_early_resp: got %b want 00", a_resp_v); end
        tick();
        tests_run++; if ({a_mem_r_v, a_mem_addr} !== {1'b1, 32'h100}) begin tests_failed++; $display("FAIL sr_hold: got %b/%h want 1/100", a_mem_r_v, a_mem_addr); end
        tick();
        a_mem_resp = 1'b1;
        a_mem_rdata = 32'hDEAD_BEEF;
        #1;
        tests_run++; if (a_resp_v !== 2'b10) begin tests_failed++; $display("FAIL sr_resp_v: got %b want 10", a_resp_v); end
        tests_run++; if (a_resp_data !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL sr_resp_data: got %h want deadbeef", a_resp_data); end
        a_r_v = 2'b00;
        tick();
        tests_run++; if ({a_grant, a_mem_r_v, a_resp_v} !== 5'd0) begin tests_failed++; $display("FAIL sr_back_idle: got %b want 0", {a_grant, a_mem_r_v, a_resp_v}); end
        tests_run++; if (a_err !== 1'b0) begin tests_failed++; $display("FAIL sr_no_err: got %b want 0", a_err); end
        a_mem_resp = 1'b0;
    endtask

    task automatic test_rr_alternate();
        int exp_port;
        int cnt0;
        int cnt1;
        logic [1:0] exp_g;
        do_reset();
        exp_port = 0; cnt0 = 0; cnt1 = 0;
        a_r_v = 2'b11;
        a_mem_resp = 1'b1;
        a_mem_rdata = 32'hA5A5_0000;
        for (int i = 0; i < 8; i++) begin
            tick();
            cnt0 += int'(a_resp_v[0]);
            cnt1 += int'(a_resp_v[1]);
            if (i % 2 == 0) begin
                exp_g = 2'b01 << exp_port;
                tests_run++; if (a_grant !== exp_g) begin tests_failed++; $display("FAIL rr_grant cyc%0d: got %b want %b", i, a_grant, exp_g); end
                tests_run++; if (a_resp_v !== exp_g) begin tests_failed++; $display("FAIL rr_resp cyc%0d: got %b want %b", i, a_resp_v, exp_g); end
                exp_port = 1 - exp_port;
            end else begin
                tests_run++; if ({a_grant, a_resp_v} !== 4'b0000) begin tests_failed++; $display("FAIL rr_idle_gap cyc%0d: got %b want 0000", i, {a_grant, a_resp_v}); end
            end
        end
        tests_run++; if (cnt0 != 2 || cnt1 != 2) begin tests_failed++; $display("FAIL rr_fair_count: got %0d/%0d want 2/2", cnt0, cnt1); end
        a_r_v = 2'b00;
        a_mem_resp = 1'b0;
        tick();
    endtask

    task automatic test_fixed_priority();
        int p1_grants;
        do_reset();
        p1_grants = 0;
        f_r_v = 2'b11;
        f_mem_resp = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            p1_grants += int'(f_grant[1]);
            if (i % 2 == 0) begin
                tests_run++; if (f_grant !== 2'b01) begin tests_failed++; $display("FAIL fx_grant cyc%0d: got %b want 01", i, f_grant); end
            end
        end
        tests_run++; if (p1_grants != 0) begin tests_failed++; $display("FAIL fx_starve: got %0d want 0", p1_grants); end
        f_r_v = 2'b10;
        tick();
        tests_run++; if (f_grant !== 2'b10) begin tests_failed++; $display("FAIL fx_p1_after_drop: got %b want 10", f_grant); end
        f_r_v = 2'b00;
        f_mem_resp = 1'b0;
        tick();
    endtask

    task automatic test_write_then_read();
        do_reset();
        a_w_v = 2'b01;
        a_addr[31:0] = 32'h40;
        a_wdata[31:0] = 32'h1234_5678;
        a_r_v = 2'b10;
        a_addr[63:32] = 32'h200;
        tick();
        tests_run++; if (a_grant !== 2'b01) begin tests_failed++; $display("FAIL wr_grant: got %b want 01", a_grant); end
        tests_run++; if ({a_mem_w_v, a_mem_r_v} !== 2'b10) begin tests_failed++; $display("FAIL wr_strobes: got %b want 10", {a_mem_w_v, a_mem_r_v}); end
        tests_run++; if ({a_mem_addr, a_mem_wdata} !== {32'h40, 32'h1234_5678}) begin tests_failed++; $display("FAIL wr_addr_data: got %h/%h want 40/12345678", a_mem_addr, a_mem_wdata); end
        a_mem_resp = 1'b1;
        #1;
        tests_run++; if (a_resp_v !== 2'b01) begin tests_failed++; $display("FAIL wr_resp: got %b want 01", a_resp_v); end
        a_w_v = 2'b00;
        tick();
        a_mem_resp = 1'b0;
        tests_run++; if (a_grant !== 2'b00) begin tests_failed++; $display("FAIL wr_no_back_to_back: got %b want 00", a_grant); end
        tick();
        tests_run++; if (a_grant !== 2'b10) begin tests_failed++; $display("FAIL rd_grant: got %b want 10", a_grant); end
        tests_run++; if ({a_mem_w_v, a_mem_r_v, a_mem_addr} !== {2'b01, 32'h200}) begin tests_failed++; $display("FAIL rd_strobes_addr: got %b/%h want 01/200", {a_mem_w_v, a_mem_r_v}, a_mem_addr); end
        a_mem_resp = 1'b1;
        a_mem_rdata = 32'hCAFE_F00D;
        #1;
        tests_run++; if ({a_resp_v, a_resp_data} !== {2'b10, 32'hCAFE_F00D}) begin tests_failed++; $display("FAIL rd_resp: got %b/%h want 10/cafef00d", a_resp_v, a_resp_data); end
        a_r_v = 2'b00;
        tick();
        a_mem_resp = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        a_r_v = 2'b01;
        a_addr[31:0] = 32'h80;
        for (int i = 1; i <= 4; i++) begin
            tick();
            tests_run++; if ({a_grant, a_mem_r_v, a_err} !== 4'b0110) begin tests_failed++; $display("FAIL to_wait cyc%0d: got %b want 0110", i, {a_grant, a_mem_r_v, a_err}); end
        end
        tick();
        tests_run++; if ({a_grant, a_mem_r_v, a_resp_v, a_err} !== 6'b000001) begin tests_failed++; $display("FAIL to_abort: got %b want 000001", {a_grant, a_mem_r_v, a_resp_v, a_err}); end
        tick();
        tests_run++; if ({a_grant, a_mem_r_v, a_err} !== 4'b0111) begin tests_failed++; $display("FAIL to_regrant: got %b want 0111", {a_grant, a_mem_r_v, a_err}); end
        a_mem_resp = 1'b1;
        #1;
        tests_run++; if (a_resp_v !== 2'b01) begin tests_failed++; $display("FAIL to_late_resp: got %b want 01", a_resp_v); end
        a_r_v = 2'b00;
        tick();
        a_mem_resp = 1'b0;
        tests_run++; if ({a_grant, a_err} !== 3'b001) begin tests_failed++; $display("FAIL to_sticky: got %b want 001", {a_grant, a_err}); end
        // Response arriving in the limit cycle wins.
        do_reset();
        a_r_v = 2'b01;
        tick(); tick(); tick(); tick();
        a_mem_resp = 1'b1;
        #1;
        tests_run++; if (a_resp_v !== 2'b01) begin tests_failed++; $display("FAIL to_edge_resp: got %b want 01", a_resp_v); end
        a_r_v = 2'b00;
        tick();
        a_mem_resp = 1'b0;
        tests_run++; if ({a_grant, a_err} !== 3'b000) begin tests_failed++; $display("FAIL to_edge_no_err: got %b want 000", {a_grant, a_err}); end
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        q_r_v = 4'b0010;
        q_addr[63:32] = 32'h300;
        q_wdata[63:32] = 32'h5555_AAAA;
        tick();
        tests_run++; if (q_grant !== 4'b0010) begin tests_failed++; $display("FAIL rmb_first_grant: got %b want 0010", q_grant); end
        rst = 1'b1;
        q_r_v = 4'b0000;
        tick();
        tests_run++; if ({q_grant, q_resp_v, q_mem_r_v, q_mem_w_v, q_err} !== 11'd0) begin tests_failed++; $display("FAIL rmb_flags: got %b want 0", {q_grant, q_resp_v, q_mem_r_v, q_mem_w_v, q_err}); end
        tests_run++; if ({q_mem_addr, q_mem_wdata} !== 64'd0) begin tests_failed++; $display("FAIL rmb_addr_data: got %h want 0", {q_mem_addr, q_mem_wdata}); end
        rst = 1'b0;
        q_r_v = 4'b1010;
        q_addr[63:32] = 32'h11;
        q_addr[127:96] = 32'h33;
        q_mem_resp = 1'b1;
        #1;
        tests_run++; if (q_resp_v !== 4'b0000) begin tests_failed++; $display("FAIL rmb_idle_resp_ignored: got %b want 0000", q_resp_v); end
        q_mem_resp = 1'b0;
        tick();
        tests_run++; if ({q_grant, q_mem_addr} !== {4'b0010, 32'h11}) begin tests_failed++; $display("FAIL rmb_ptr_cleared: got %b/%h want 0010/11", q_grant, q_mem_addr); end
        q_mem_resp = 1'b1;
        #1;
        q_r_v = 4'b1000;
        tick();
        q_mem_resp = 1'b0;
        tick();
        tests_run++; if ({q_grant, q_mem_addr} !== {4'b1000, 32'h33}) begin tests_failed++; $display("FAIL rmb_next_port3: got %b/%h want 1000/33", q_grant, q_mem_addr); end
        q_mem_resp = 1'b1;
        #1;
        q_r_v = 4'b0000;
        tick();
        q_mem_resp = 1'b0;
    endtask

    // Random traffic on the 4-port instance against a transaction-level model:
    // the bus is either free or owned; a free bus hands the next owner to the
    // first requester found scanning cyclically from the port after the last
    // owner; a response frees the bus for one idle cycle.
    task automatic test_random();
        bit m_busy;
        bit m_resp_prev;
        int m_owner;
        int m_ptr;
        int m_wait;
        int n_resp;
        bit act[4];
        logic [3:0] pend_prev;
        logic [3:0] exp_g;
        logic exp_w;
        do_reset();
        exp_q.delete();
        m_busy = 0; m_resp_prev = 0; m_owner = 0; m_ptr = 0; m_wait = 0; n_resp = 0;
        pend_prev = '0;
        for (int p = 0; p < 4; p++) act[p] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            tick();
            if (m_resp_prev) begin
                m_busy = 0;
            end else if (!m_busy && pend_prev != 4'b0000) begin
                for (int k = 0; k < 4; k++) begin
                    if (pend_prev[(m_ptr + k) % 4]) begin
                        m_owner = (m_ptr + k) % 4;
                        break;
                    end
                end
                m_busy = 1;
                m_ptr = (m_owner + 1) % 4;
                m_wait = $urandom_range(0, 5);
            end
            m_resp_prev = 0;
            exp_g = m_busy ? (4'b0001 << m_owner) : 4'b0000;
            tests_run++; if (q_grant !== exp_g) begin tests_failed++; $display("FAIL rnd_grant cyc%0d: got %b want %b", cyc, q_grant, exp_g); end
            if (m_busy) begin
                exp_w = q_w_v[m_owner];
                tests_run++; if ({q_mem_w_v, q_mem_r_v} !== {exp_w, ~exp_w}) begin tests_failed++; $display("FAIL rnd_strobes cyc%0d: got %b want %b", cyc, {q_mem_w_v, q_mem_r_v}, {exp_w, ~exp_w}); end
                tests_run++; if ({q_mem_addr, q_mem_wdata} !== {q_addr[m_owner*W +: W], q_wdata[m_owner*W +: W]}) begin tests_failed++; $display("FAIL rnd_addr_data cyc%0d: got %h/%h want %h/%h", cyc, q_mem_addr, q_mem_wdata, q_addr[m_owner*W +: W], q_wdata[m_owner*W +: W]); end
            end else begin
                tests_run++; if ({q_mem_w_v, q_mem_r_v} !== 2'b00) begin tests_failed++; $display("FAIL rnd_idle_strobes cyc%0d: got %b want 00", cyc, {q_mem_w_v, q_mem_r_v}); end
            end
            tests_run++; if (q_err !== 1'b0) begin tests_failed++; $display("FAIL rnd_err cyc%0d: got %b want 0", cyc, q_err); end
            for (int p = 0; p < 4; p++) begin
                if (!act[p] && $urandom_range(0, 2) == 0) begin
                    int kind;
                    kind = $urandom_range(0, 2);
                    act[p] = 1;
                    q_r_v[p] = (kind != 1);
                    q_w_v[p] = (kind != 0);
                    q_addr[p*W +: W] = $urandom();
                    q_wdata[p*W +: W] = $urandom();
                end
            end
            q_mem_rdata = $urandom();
            if (m_busy && m_wait == 0) begin
                q_mem_resp = 1'b1;
                exp_q.push_back(q_mem_rdata);
            end else begin
                q_mem_resp = !m_busy && ($urandom_range(0, 3) == 0);
                if (m_busy) m_wait--;
            end
            #1;
            if (m_busy && q_mem_resp) begin
                tests_run++; if (q_resp_v !== exp_g) begin tests_failed++; $display("FAIL rnd_resp_v cyc%0d: got %b want %b", cyc, q_resp_v, exp_g); end
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++; $display("FAIL rnd_resp_data cyc%0d: got %h want none queued", cyc, q_resp_data);
                end else if (q_resp_data !== exp_q[0]) begin
                    tests_failed++; $display("FAIL rnd_resp_data cyc%0d: got %h want %h", cyc, q_resp_data, exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                act[m_owner] = 0;
                q_r_v[m_owner] = 1'b0;
                q_w_v[m_owner] = 1'b0;
                m_resp_prev = 1;
                n_resp++;
            end else begin
                tests_run++; if (q_resp_v !== 4'b0000) begin tests_failed++; $display("FAIL rnd_no_resp cyc%0d: got %b want 0000", cyc, q_resp_v); end
            end
            pend_prev = q_r_v | q_w_v;
        end
        tests_run++; if (n_resp < 20) begin tests_failed++; $display("FAIL rnd_progress: got %0d responses want at least 20", n_resp); end
        clear_inputs();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_rr_alternate();
        test_fixed_priority();
        test_write_then_read();
        test_timeout();
        test_reset_mid_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
